// File: rtl/seq_mul_ctrl_if.sv
// seq_mul_ctrl_if: signal bundle between the shift-and-add multiplier controller,
// its requester and the external combinational adder.
//   w_start, w_a, w_b  : request and operands (requester -> controller)
//   w_busy, w_done, w_p: status and product   (controller -> requester)
//   w_add_a, w_add_b   : adder operands       (controller -> adder)
//   w_add_s            : adder sum            (adder -> controller)
// Modports: slave is the controller side, master is the environment side
// (requester plus adder).
interface seq_mul_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         w_start;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic         w_busy;
    logic         w_done;
    logic [W-1:0] w_p;
    logic [W-1:0] w_add_a;
    logic [W-1:0] w_add_b;
    logic [W-1:0] w_add_s;

    modport slave (
        input  w_start, w_a, w_b, w_add_s,
        output w_busy, w_done, w_p, w_add_a, w_add_b
    );

    modport master (
        output w_start, w_a, w_b, w_add_s,
        input  w_busy, w_done, w_p, w_add_a, w_add_b
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: multi-cycle shift-and-add multiplier controller producing the low W bits
// of a*b. Each RUN cycle it presents {accumulator, shifted multiplicand or 0} to an
// external combinational adder and registers the returned sum as the new accumulator.
// Ports:
//   w_clk : clock, rising edge
//   w_rst : synchronous active-high reset
//   bus   : seq_mul_ctrl_if slave modport (start/a/b in, busy/done/p out,
//           add_a/add_b to the adder, add_s from the adder)
// Parameters:
//   W          : operand/result width, must match the attached adder
//   EARLY_EXIT : 1 = finish as soon as the remaining multiplier bits are all zero
module seq_mul_ctrl #(
    parameter int unsigned W          = 32,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input logic          w_clk,
    input logic          w_rst,
    seq_mul_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   p_q, p_d;

    logic           busy;
    logic           done;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy     = 1'b0;
        done     = 1'b0;
        add_a    = '0;
        add_b    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.w_start) begin
                    mcand_d  = bus.w_a;
                    mplier_d = bus.w_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end

            StRun: begin
                busy  = 1'b1;
                add_a = acc_q;
                add_b = mplier_q[0] ? mcand_q : '0;
                if (EARLY_EXIT && (mplier_q == '0)) begin
                    // Nothing left to add: acc already holds the product.
                    p_d     = acc_q;
                    state_d = StDone;
                end else begin
                    acc_d    = bus.w_add_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        // Load p with the final sum so it is valid during DONE.
                        p_d     = bus.w_add_s;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.w_busy  = busy;
    assign bus.w_done  = done;
    assign bus.w_p     = p_q;
    assign bus.w_add_a = add_a;
    assign bus.w_add_b = add_b;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl: one instance with EARLY_EXIT=0 and one with EARLY_EXIT=1 share
// clock, reset and request inputs; each drives its own behavioural adder. A timing and
// arithmetic model predicts busy/done/p/add_a/add_b every cycle.
module tb_seq_mul_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;

    always #5 clk = ~clk;

    seq_mul_ctrl_if #(.W(W)) bus0 ();
    seq_mul_ctrl_if #(.W(W)) bus1 ();

    assign bus0.w_start = start;
    assign bus0.w_a     = a;
    assign bus0.w_b     = b;
    assign bus0.w_add_s = bus0.w_add_a + bus0.w_add_b;
    assign bus1.w_start = start;
    assign bus1.w_a     = a;
    assign bus1.w_b     = b;
    assign bus1.w_add_s = bus1.w_add_a + bus1.w_add_b;

    seq_mul_ctrl #(.W(W), .EARLY_EXIT(1'b0)) u_dut0 (
        .w_clk(clk),
        .w_rst(rst),
        .bus  (bus0)
    );

    seq_mul_ctrl #(.W(W), .EARLY_EXIT(1'b1)) u_dut1 (
        .w_clk(clk),
        .w_rst(rst),
        .bus  (bus1)
    );

    logic         busy_o[2];
    logic         done_o[2];
    logic [W-1:0] p_o[2];
    logic [W-1:0] adda_o[2];
    logic [W-1:0] addb_o[2];

    assign busy_o[0] = bus0.w_busy;
    assign busy_o[1] = bus1.w_busy;
    assign done_o[0] = bus0.w_done;
    assign done_o[1] = bus1.w_done;
    assign p_o[0]    = bus0.w_p;
    assign p_o[1]    = bus1.w_p;
    assign adda_o[0] = bus0.w_add_a;
    assign adda_o[1] = bus1.w_add_a;
    assign addb_o[0] = bus0.w_add_b;
    assign addb_o[1] = bus1.w_add_b;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           cyc = 0;
    int           run_left[2] = '{0, 0};
    int           run_len[2]  = '{0, 0};
    bit           in_done[2]  = '{0, 0};
    logic [W-1:0] m_a[2]      = '{'0, '0};
    logic [W-1:0] m_b[2]      = '{'0, '0};
    logic [W-1:0] exp_p[2]    = '{'0, '0};

    // Cycles from acceptance to DONE: W, or (highest set bit index + 1) + 1 capped at W.
    function automatic int lat(input int inst, input logic [W-1:0] bv);
        int k;
        if (inst == 0) return W;
        k = 0;
        for (int j = 0; j < W; j++) if (bv[j]) k = j + 1;
        return (k + 1 > W) ? W : k + 1;
    endfunction

    // Sum of the first s partial products: a * (b mod 2^s), mod 2^W.
    function automatic logic [W-1:0] partial(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input int s);
        logic [W-1:0] low;
        low = '0;
        for (int j = 0; j < s; j++) low[j] = mb[j];
        return ma * low;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    run_left[i] = 0;
                    in_done[i]  = 1'b0;
                    exp_p[i]    = '0;
                end else if (in_done[i]) begin
                    in_done[i] = 1'b0;
                end else if (run_left[i] > 0) begin
                    run_left[i]--;
                    if (run_left[i] == 0) begin
                        in_done[i] = 1'b1;
                        exp_p[i]   = m_a[i] * m_b[i];
                    end
                end else if (start) begin
                    m_a[i]      = a;
                    m_b[i]      = b;
                    run_len[i]  = lat(i, b);
                    run_left[i] = run_len[i];
                end
            end
        end
    end

    // ---------------- per-cycle compare + done monitor ----------------
    int           done_cnt[2] = '{0, 0};
    int           busy_cnt[2] = '{0, 0};
    int           done_cyc[2] = '{0, 0};
    logic [W-1:0] done_p[2]   = '{'0, '0};

    initial begin
        int           s;
        bit           run;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                run = (run_left[i] > 0);
                s   = run_len[i] - run_left[i];
                ea  = run ? partial(m_a[i], m_b[i], s) : '0;
                eb  = (run && m_b[i][s]) ? (m_a[i] << s) : '0;
                chk($sformatf("busy%0d", i), W'(busy_o[i]), W'(run));
                chk($sformatf("done%0d", i), W'(done_o[i]), W'(in_done[i]));
                chk($sformatf("p%0d", i), p_o[i], exp_p[i]);
                chk($sformatf("add_a%0d", i), adda_o[i], ea);
                chk($sformatf("add_b%0d", i), addb_o[i], eb);
                if (busy_o[i] === 1'b1) busy_cnt[i]++;
                if (done_o[i] === 1'b1) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                    done_p[i]   = p_o[i];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            if (run_left[0] == 0 && run_left[1] == 0 && !in_done[0] && !in_done[1]) return;
            @(negedge clk);
            #1;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            #1;
            if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd1, 32'd0);
    endtask

    // Issue a*b; if intr_at >= 0, pulse a 9*9 request intr_at cycles after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int intr_at,
                          output int t0);
        logic [W-1:0] prod;
        bit           ok;
        prod = ta * tb_v;
        wait_idle();
        @(negedge clk);
        done_cnt = '{0, 0};
        busy_cnt = '{0, 0};
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        ok    = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (n == intr_at) begin
                start = 1'b1;
                a     = 9;
                b     = 9;
            end else if (n == intr_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
            if (done_cnt[0] > 0 && done_cnt[1] > 0 && n > intr_at + 1) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) chk("done_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ndone%0d", i), W'(done_cnt[i]), 32'd1);
            chk($sformatf("prod%0d", i), done_p[i], prod);
        end
    endtask

    initial begin
        int t0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_p0", p_o[0], 32'd0);
        chk("reset_busy1", W'(busy_o[1]), 32'd0);
        rst = 1'b0;

        // Hand-computed anchors
        run_op(32'd321, 32'd4444, -1, t0);
        chk("321x4444_p0", done_p[0], 32'd1426524);
        chk("321x4444_p1", done_p[1], 32'd1426524);
        chk("321x4444_lat0", W'(done_cyc[0] - t0), 32'd32);
        chk("321x4444_busy0", W'(busy_cnt[0]), 32'd32);
        chk("321x4444_lat1", W'(done_cyc[1] - t0), 32'd14);

        run_op(32'd1024, 32'd2048, -1, t0);
        chk("1024x2048_p", done_p[0], 32'd2097152);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, t0);
        chk("wrap_p0", done_p[0], 32'h0000_0001);
        chk("wrap_p1", done_p[1], 32'h0000_0001);

        run_op(32'd0, 32'h1234_5678, -1, t0);
        chk("zero_a_p", done_p[0], 32'd0);

        run_op(32'd1024, 32'd1, -1, t0);
        chk("ee_1024x1_p1", done_p[1], 32'd1024);
        chk("ee_1024x1_lat1", W'(done_cyc[1] - t0), 32'd2);

        run_op(32'd7, 32'd0, -1, t0);
        chk("ee_b0_lat1", W'(done_cyc[1] - t0), 32'd1);

        // Start during RUN is ignored
        run_op(32'd7, 32'd6, 2, t0);
        chk("ignore_p0", done_p[0], 32'd42);
        chk("ignore_p1", done_p[1], 32'd42);

        // Reset mid-operation at cycle 10
        wait_idle();
        @(negedge clk);
        done_cnt = '{0, 0};
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        while (cyc < t0 + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("rst_ndone0", W'(done_cnt[0]), 32'd0);
        chk("rst_p0", p_o[0], 32'd0);
        chk("rst_p1", p_o[1], 32'd0);
        chk("rst_busy0", W'(busy_o[0]), 32'd0);
        run_op(32'd3, 32'd3, -1, t0);
        chk("after_rst_p", done_p[0], 32'd9);

        // Back-to-back: start held through DONE (ignored) and the following IDLE (accepted)
        wait_idle();
        @(negedge clk);
        done_cnt = '{0, 0};
        start = 1'b1;
        a     = 32'h11;
        b     = 32'h8000_0001;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("b2b_first_p", done_p[0], 32'h8000_0011);
        done_cnt = '{0, 0};
        start = 1'b1;
        a     = 32'd3;
        b     = 32'h8000_0005;
        repeat (2) @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        wait_done();
        chk("b2b_second_p0", done_p[0], 32'h8000_000F);
        chk("b2b_second_p1", done_p[1], 32'h8000_000F);
        chk("b2b_second_lat0", W'(done_cyc[0] - t0), 32'd32);

        // Random pairs
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op(ra, rb, -1, t0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
